// File: rtl/lsu_misalign_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : lsu_misalign_sequencer
// Purpose : Load/store sequencer in front of data memory; splits misaligned
//           halfword/word accesses into byte beats and reassembles loads.
// Revision: 1.0
// ============================================================================
module lsu_misalign_sequencer #(
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_RD
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BEAT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_SB  = 3'b000;

    state_t      r_state, w_state_nx;
    logic [1:0]  r_cnt, r_last;
    logic        r_we, r_split;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr, r_wdata, r_asm;
    logic [31:0] r_resp_rdata, r_mem_a, r_mem_wd;
    logic        r_resp_err;
    logic [2:0]  r_mem_f3;

    logic        w_illegal, w_mis, w_err, w_accept, w_beat_last;
    logic [1:0]  w_last, w_cnt_nx;
    logic [31:0] w_asm, w_result;

    // Request decode: legality, misalignment and number of beats minus one
    always_comb begin
        w_illegal = req_we ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                           : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
        w_mis     = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                 || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        w_err     = w_illegal || (w_mis && (ALLOW_MISALIGNED == 0));
        w_last    = !w_mis ? 2'd0 : ((req_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3);
    end

    always_comb begin
        w_state_nx = r_state;
        req_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nx = w_err ? S_RESP : S_BEAT;
            end
            S_BEAT: if (r_cnt == r_last) w_state_nx = S_RESP;
            S_RESP: w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    assign w_accept    = (r_state == S_IDLE) && req_valid;
    assign w_beat_last = (r_state == S_BEAT) && (r_cnt == r_last);
    assign w_cnt_nx    = r_cnt + 2'd1;

    // Merge this beat's read data into the assembly register, then extend
    always_comb begin
        w_asm = r_asm;
        if (r_split) w_asm[{r_cnt, 3'b000} +: 8] = mem_RD[7:0];
        else         w_asm = mem_RD;
        w_result = w_asm;
        if (r_we) begin
            w_result = 32'd0;
        end else if (r_split) begin
            case (r_funct3)
                3'b001:  w_result = {{16{w_asm[15]}}, w_asm[15:0]};
                3'b101:  w_result = {16'd0, w_asm[15:0]};
                default: w_result = w_asm;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt        <= 2'd0;
            r_last       <= 2'd0;
            r_we         <= 1'b0;
            r_split      <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_asm        <= 32'd0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            r_mem_a      <= 32'd0;
            r_mem_wd     <= 32'd0;
            r_mem_f3     <= 3'b010;
        end else if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_split  <= w_mis;
            r_last   <= w_last;
            r_cnt    <= 2'd0;
            r_asm    <= 32'd0;
            if (w_err) begin
                r_resp_err   <= 1'b1;
                r_resp_rdata <= 32'd0;
            end else begin
                r_mem_a  <= req_addr;
                r_mem_wd <= w_mis ? {24'd0, req_wdata[7:0]} : req_wdata;
                r_mem_f3 <= w_mis ? (req_we ? c_F3_SB : c_F3_LBU) : req_funct3;
            end
        end else if (r_state == S_BEAT) begin
            r_asm <= w_asm;
            if (w_beat_last) begin
                r_resp_rdata <= w_result;
                r_resp_err   <= 1'b0;
            end else begin
                // Only split accesses have more than one beat
                r_cnt    <= w_cnt_nx;
                r_mem_a  <= r_addr + {30'd0, w_cnt_nx};
                r_mem_wd <= {24'd0, r_wdata[{w_cnt_nx, 3'b000} +: 8]};
            end
        end
    end

    assign mem_WE     = (r_state == S_BEAT) && r_we;
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_A      = r_mem_a;
    assign mem_WD     = r_mem_wd;
    assign mem_funct3 = r_mem_f3;

endmodule
`default_nettype wire

// File: tb/tb_lsu_misalign_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_misalign_sequencer
// Purpose : Self-checking bench with a byte memory model and response queue.
// Revision: 1.0
// ============================================================================
module tb_lsu_misalign_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        req_valid = 1'b0, req_valid1 = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;

    logic        req_ready, resp_valid, resp_err, mem_WE;
    logic [31:0] resp_rdata, mem_A, mem_WD, mem_RD;
    logic [2:0]  mem_funct3;
    logic        req_ready_1, resp_valid_1, resp_err_1, mem_WE_1;
    logic [31:0] resp_rdata_1, mem_A_1, mem_WD_1;
    logic [2:0]  mem_funct3_1;

    int tests_run = 0;
    int failed    = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;
    resp_t sb_q[$];

    logic [7:0] mem [0:255];

    always #5 CLK = ~CLK;

    lsu_misalign_sequencer #(.ALLOW_MISALIGNED(1)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE),
        .mem_funct3(mem_funct3), .mem_RD(mem_RD)
    );

    lsu_misalign_sequencer #(.ALLOW_MISALIGNED(0)) dut_strict (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid1), .req_ready(req_ready_1), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_1), .resp_rdata(resp_rdata_1), .resp_err(resp_err_1),
        .mem_A(mem_A_1), .mem_WD(mem_WD_1), .mem_WE(mem_WE_1),
        .mem_funct3(mem_funct3_1), .mem_RD(32'hCAFEF00D)
    );

    // Little-endian byte memory, 256 bytes aliased on address[7:0]
    always_comb begin
        logic [7:0] a;
        a = mem_A[7:0];
        case (mem_funct3)
            3'b000:  mem_RD = {{24{mem[a][7]}}, mem[a]};
            3'b001:  mem_RD = {{16{mem[a+8'd1][7]}}, mem[a+8'd1], mem[a]};
            3'b100:  mem_RD = {24'd0, mem[a]};
            3'b101:  mem_RD = {16'd0, mem[a+8'd1], mem[a]};
            default: mem_RD = {mem[a+8'd3], mem[a+8'd2], mem[a+8'd1], mem[a]};
        endcase
    end

    always @(posedge CLK) begin
        if (mem_WE) begin
            case (mem_funct3)
                3'b000: mem[mem_A[7:0]] <= mem_WD[7:0];
                3'b001: for (int i = 0; i < 2; i++) mem[mem_A[7:0] + 8'(i)] <= mem_WD[8*i +: 8];
                default: for (int i = 0; i < 4; i++) mem[mem_A[7:0] + 8'(i)] <= mem_WD[8*i +: 8];
            endcase
        end
    end

    // Response scoreboard
    always @(negedge CLK) begin
        if (RST_N && resp_valid) begin
            resp_t e;
            tests_run++;
            if (sb_q.size() == 0) begin
                failed++;
                $display("FAIL resp_unexpected: got rdata=%h err=%b, required no response", resp_rdata, resp_err);
            end else begin
                e = sb_q.pop_front();
                if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                    failed++;
                    $display("FAIL resp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                             resp_rdata, resp_err, e.rdata, e.err);
                end
            end
        end
    end

    // Caller is #1 after a rising edge; returns #1 after the edge where IDLE resumes
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int nb,
                          input logic [31:0] exp_rd, input logic exp_err);
        logic [2:0]  ef3;
        logic [31:0] ea, ewd;
        int bad;
        sb_q.push_back({exp_rd, exp_err});
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        ef3 = (nb > 1) ? (we ? 3'b000 : 3'b100) : f3;
        for (int k = 0; k < nb; k++) begin
            ea  = addr + 32'(k);
            ewd = (nb > 1) ? ((wdata >> (8 * k)) & 32'hFF) : wdata;
            bad = 0;
            if (mem_A !== ea || mem_WE !== we || mem_funct3 !== ef3) bad = 1;
            if (we && mem_WD !== ewd) bad = 1;
            if (req_ready !== 1'b0 || resp_valid !== 1'b0) bad = 1;
            tests_run++;
            if (bad != 0) begin
                failed++;
                $display("FAIL beat%0d: got A=%h WE=%b f3=%b WD=%h rdy=%b rv=%b, required A=%h WE=%b f3=%b WD=%h rdy=0 rv=0",
                         k, mem_A, mem_WE, mem_funct3, mem_WD, req_ready, resp_valid, ea, we, ef3, ewd);
            end
            @(posedge CLK); #1;
        end
        tests_run++;
        if (resp_valid !== 1'b1 || mem_WE !== 1'b0 || req_ready !== 1'b0) begin
            failed++;
            $display("FAIL resp_cycle: got rv=%b WE=%b rdy=%b, required rv=1 WE=0 rdy=0", resp_valid, mem_WE, req_ready);
        end
        @(posedge CLK); #1;
        tests_run++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failed++;
            $display("FAIL back_idle: got rv=%b rdy=%b, required rv=0 rdy=1", resp_valid, req_ready);
        end
    endtask

    task automatic check_byte(input logic [7:0] a, input logic [7:0] exp);
        tests_run++;
        if (mem[a] !== exp) begin
            failed++;
            $display("FAIL mem_byte[%h]: got %h, required %h", a, mem[a], exp);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        tests_run++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0 ||
            mem_WE !== 1'b0 || mem_A !== 32'd0 || mem_WD !== 32'd0 || mem_funct3 !== 3'b010) begin
            failed++;
            $display("FAIL reset_state: got rdy=%b rv=%b err=%b rd=%h WE=%b A=%h WD=%h f3=%b, required 1 0 0 0 0 0 0 010",
                     req_ready, resp_valid, resp_err, resp_rdata, mem_WE, mem_A, mem_WD, mem_funct3);
        end
        RST_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_aligned();
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'd0, 1'b0);
        do_req(1'b0, 3'b010, 32'h10, 32'd0, 1, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_split_word();
        do_req(1'b1, 3'b010, 32'h05, 32'h11223344, 4, 32'd0, 1'b0);
        check_byte(8'h05, 8'h44);
        check_byte(8'h08, 8'h11);
        do_req(1'b0, 3'b010, 32'h05, 32'd0, 4, 32'h11223344, 1'b0);
    endtask

    task automatic test_split_half();
        do_req(1'b1, 3'b000, 32'h03, 32'h00000080, 1, 32'd0, 1'b0);
        do_req(1'b1, 3'b000, 32'h04, 32'h123456FF, 1, 32'd0, 1'b0);
        do_req(1'b0, 3'b001, 32'h03, 32'd0, 2, 32'hFFFFFF80, 1'b0);
        do_req(1'b0, 3'b101, 32'h03, 32'd0, 2, 32'h0000FF80, 1'b0);
    endtask

    task automatic test_errors();
        do_req(1'b1, 3'b100, 32'h30, 32'hFFFFFFFF, 0, 32'd0, 1'b1);
        do_req(1'b0, 3'b011, 32'h30, 32'd0, 0, 32'd0, 1'b1);
        do_req(1'b0, 3'b110, 32'h30, 32'd0, 0, 32'd0, 1'b1);
        // A good response after an error must clear resp_err
        do_req(1'b0, 3'b100, 32'h05, 32'd0, 1, 32'h00000044, 1'b0);
        check_byte(8'h30, 8'hxx);
    endtask

    task automatic test_strict();
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h02; req_valid1 = 1'b1;
        @(posedge CLK); #1;
        req_valid1 = 1'b0;
        tests_run++;
        if (resp_valid_1 !== 1'b1 || resp_err_1 !== 1'b1 || resp_rdata_1 !== 32'd0 || mem_WE_1 !== 1'b0) begin
            failed++;
            $display("FAIL strict_misalign: got rv=%b err=%b rd=%h WE=%b, required 1 1 0 0",
                     resp_valid_1, resp_err_1, resp_rdata_1, mem_WE_1);
        end
        @(posedge CLK); #1;
        req_addr = 32'h04; req_valid1 = 1'b1;
        @(posedge CLK); #1;
        req_valid1 = 1'b0;
        @(posedge CLK); #1;
        tests_run++;
        if (resp_valid_1 !== 1'b1 || resp_err_1 !== 1'b0 || resp_rdata_1 !== 32'hCAFEF00D) begin
            failed++;
            $display("FAIL strict_aligned: got rv=%b err=%b rd=%h, required 1 0 cafef00d",
                     resp_valid_1, resp_err_1, resp_rdata_1);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_wrap();
        do_req(1'b1, 3'b010, 32'hFFFFFFFE, 32'h04030201, 4, 32'd0, 1'b0);
        check_byte(8'h00, 8'h03);
        do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, 4, 32'h04030201, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_req(1'b1, 3'b001, 32'h20, 32'h7777ABCD, 1, 32'd0, 1'b0);
        do_req(1'b0, 3'b101, 32'h20, 32'd0, 1, 32'h0000ABCD, 1'b0);
        do_req(1'b0, 3'b000, 32'h21, 32'd0, 1, 32'hFFFFFFAB, 1'b0);
        do_req(1'b1, 3'b001, 32'h23, 32'h99995A6B, 2, 32'd0, 1'b0);
        do_req(1'b0, 3'b001, 32'h23, 32'd0, 2, 32'h00005A6B, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_req(1'b1, 3'b010, 32'h40, 32'h00000000, 1, 32'd0, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h41; req_wdata = 32'hA1B2C3D4;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        tests_run++;
        if (mem_WE !== 1'b1 || mem_A !== 32'h43) begin
            failed++;
            $display("FAIL pre_abort_beat2: got WE=%b A=%h, required WE=1 A=00000043", mem_WE, mem_A);
        end
        RST_N = 1'b0;
        #1;
        tests_run++;
        if (mem_WE !== 1'b0 || resp_valid !== 1'b0) begin
            failed++;
            $display("FAIL abort_we: got WE=%b rv=%b, required WE=0 rv=0", mem_WE, resp_valid);
        end
        @(posedge CLK); #1;
        RST_N = 1'b1;
        repeat (3) begin @(posedge CLK); #1; end
        tests_run++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failed++;
            $display("FAIL abort_idle: got rdy=%b rv=%b, required rdy=1 rv=0", req_ready, resp_valid);
        end
        check_byte(8'h41, 8'hD4);
        check_byte(8'h42, 8'hC3);
        check_byte(8'h43, 8'h00);
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_split_word();
        test_split_half();
        test_errors();
        test_strict();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        tests_run++;
        if (sb_q.size() != 0) begin
            failed++;
            $display("FAIL missing_resp: got %0d outstanding, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
`default_nettype wire
